// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds the FSM state encoding, the default operand width and the 7-seg glyphs.
package div_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        HOLD
    } state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/divider_8_hex_driver.sv
// Combinational nibble-to-glyph decoder for one active-low seven-segment digit.
module hex_driver (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import div_pkg::*;

    always_comb begin
        seg = SEG_0;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/divider_8.sv
// Sequential signed restoring divider: B / switches -> quotient in B, remainder in A.
// One quotient bit per cycle on magnitudes, signs fixed up at the end (C truncation).
module divider_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             execute,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             div0,
    output logic [6:0]       AhexL,
    output logic [6:0]       AhexU,
    output logic [6:0]       BhexL,
    output logic [6:0]       BhexU
);
    import div_pkg::*;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t                  state;
    logic [WIDTH-1:0]        q;
    logic [WIDTH-1:0]        m;
    logic [WIDTH:0]          r;
    logic [CNT_W-1:0]        count;
    logic                    sign_q;
    logic                    sign_r;

    logic [WIDTH:0]          r_sh;
    logic [WIDTH-1:0]        q_sh;
    logic signed [WIDTH+1:0] trial;
    logic [WIDTH-1:0]        b_mag;
    logic [WIDTH-1:0]        d_mag;

    // Unsigned magnitude; the most negative value maps onto itself (|0x80| = 0x80).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    always_comb begin
        r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
        q_sh  = {q[WIDTH-2:0], 1'b0};
        trial = $signed({1'b0, r_sh}) - $signed({2'b00, m});
        b_mag = magnitude(Bval);
        d_mag = magnitude(switches);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            Aval   <= '0;
            Bval   <= '0;
            div0   <= 1'b0;
            q      <= '0;
            m      <= '0;
            r      <= '0;
            count  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!clear) begin
                        Bval <= switches;
                        Aval <= '0;
                        div0 <= 1'b0;
                    end else if (!execute) begin
                        state <= PREP;
                    end
                end
                PREP: begin
                    sign_q <= Bval[WIDTH-1] ^ switches[WIDTH-1];
                    sign_r <= Bval[WIDTH-1];
                    q      <= b_mag;
                    m      <= d_mag;
                    r      <= '0;
                    count  <= '0;
                    if (switches == '0) begin
                        Bval  <= '1;
                        Aval  <= Bval;
                        div0  <= 1'b1;
                        state <= HOLD;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    // Restoring step: keep the subtraction only when it did not go negative
                    if (!trial[WIDTH+1]) begin
                        r <= trial[WIDTH:0];
                        q <= {q_sh[WIDTH-1:1], 1'b1};
                    end else begin
                        r <= r_sh;
                        q <= q_sh;
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Bval  <= apply_sign(q, sign_q);
                    Aval  <= apply_sign(r[WIDTH-1:0], sign_r);
                    state <= HOLD;
                end
                HOLD: begin
                    if (execute) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    hex_driver u_hex_al (.nibble(Aval[3:0]), .seg(AhexL));
    hex_driver u_hex_au (.nibble(Aval[7:4]), .seg(AhexU));
    hex_driver u_hex_bl (.nibble(Bval[3:0]), .seg(BhexL));
    hex_driver u_hex_bu (.nibble(Bval[7:4]), .seg(BhexU));

endmodule

// File: tb/tb_divider_8.sv
// Randomized and directed bench for divider_8 against a C-semantics arithmetic model.
module tb_divider_8;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       execute;
    logic [7:0] switches;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       div0;
    logic [6:0] AhexL, AhexU, BhexL, BhexU;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_a, exp_b;
    logic       exp_d0;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    divider_8 dut (
        .clk(clk), .reset(reset), .clear(clear), .execute(execute),
        .switches(switches), .Aval(Aval), .Bval(Bval), .div0(div0),
        .AhexL(AhexL), .AhexU(AhexU), .BhexL(BhexL), .BhexU(BhexU)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, req);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, " A"}, 32'(Aval), 32'(exp_a));
        chk({tag, " B"}, 32'(Bval), 32'(exp_b));
        chk({tag, " div0"}, 32'(div0), 32'(exp_d0));
        chk({tag, " AhexL"}, 32'(AhexL), 32'(GLYPH[exp_a[3:0]]));
        chk({tag, " AhexU"}, 32'(AhexU), 32'(GLYPH[exp_a[7:4]]));
        chk({tag, " BhexL"}, 32'(BhexL), 32'(GLYPH[exp_b[3:0]]));
        chk({tag, " BhexU"}, 32'(BhexU), 32'(GLYPH[exp_b[7:4]]));
    endtask

    // Reference: plain integer division with truncation toward zero.
    task automatic model_div(input logic [7:0] d);
        int a, dd, qq, rr;
        if (d == 8'h00) begin
            exp_a  = exp_b;
            exp_b  = 8'hFF;
            exp_d0 = 1'b1;
        end else begin
            a  = int'($signed(exp_b));
            dd = int'($signed(d));
            qq = a / dd;
            rr = a % dd;
            exp_b = qq[7:0];
            exp_a = rr[7:0];
        end
    endtask

    task automatic do_clear(input logic [7:0] v);
        switches = v;
        clear = 1'b0;
        cyc(1);
        clear = 1'b1;
        cyc(1);
        exp_b = v; exp_a = 8'h00; exp_d0 = 1'b0;
    endtask

    // Holds execute for 'hold' cycles, scrambles switches after PREP and pokes clear during HOLD.
    task automatic do_div(input logic [7:0] d, input int hold);
        switches = d;
        execute = 1'b0;
        cyc(2);
        switches = 8'($urandom);
        cyc(hold - 2);
        clear = 1'b0;
        cyc(1);
        clear = 1'b1;
        execute = 1'b1;
        cyc(2);
        model_div(d);
    endtask

    initial begin
        logic [7:0] v, d;
        reset = 1'b0; clear = 1'b1; execute = 1'b1; switches = 8'h00;
        exp_a = 8'h00; exp_b = 8'h00; exp_d0 = 1'b0;
        cyc(2);
        chk_all("reset");
        reset = 1'b1;
        cyc(1);

        // Latency: results must be present 11 edges after execute goes low
        do_clear(8'h3B);
        switches = 8'h07;
        execute = 1'b0;
        cyc(11);
        chk("lat B", 32'(Bval), 32'h08);
        chk("lat A", 32'(Aval), 32'h03);
        chk("lat div0", 32'(div0), 32'h0);
        execute = 1'b1;
        cyc(2);

        do_clear(8'hC5); do_div(8'h07, 12); chk_all("-59/7");
        do_clear(8'h3B); do_div(8'hF9, 12); chk_all("59/-7");
        do_clear(8'hC5); do_div(8'hF9, 12); chk_all("-59/-7");
        do_clear(8'h3B); do_div(8'h00, 12); chk_all("div by zero");
        do_clear(8'h3B); chk_all("clear after div0");

        do_clear(8'h40);
        for (int i = 0; i < 5; i++) begin
            do_div(8'h02, 20);
            chk_all("chain /2");
        end

        // Both buttons low in IDLE: load happens, no division follows
        switches = 8'h3B;
        clear = 1'b0; execute = 1'b0;
        cyc(1);
        clear = 1'b1; execute = 1'b1;
        cyc(12);
        exp_b = 8'h3B; exp_a = 8'h00; exp_d0 = 1'b0;
        chk_all("clear wins");

        // Reset during ITER aborts; outputs untouched until then
        switches = 8'h07;
        execute = 1'b0;
        cyc(6);
        chk("mid-iter B", 32'(Bval), 32'h3B);
        chk("mid-iter A", 32'(Aval), 32'h00);
        reset = 1'b0;
        #1;
        exp_a = 8'h00; exp_b = 8'h00; exp_d0 = 1'b0;
        chk_all("async reset");
        cyc(2);
        execute = 1'b1;
        reset = 1'b1;
        cyc(1);
        do_clear(8'h3B); do_div(8'h07, 12); chk_all("after reset");
        do_clear(8'h80); do_div(8'hFF, 12); chk_all("0x80/-1");
        do_clear(8'h80); do_div(8'h01, 12); chk_all("0x80/1");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                v = 8'($urandom);
                do_clear(v);
            end
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            do_div(d, int'($urandom_range(11, 20)));
            chk("rand A", 32'(Aval), 32'(exp_a));
            chk("rand B", 32'(Bval), 32'(exp_b));
            chk("rand div0", 32'(div0), 32'(exp_d0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
